// File: rtl/store_rmw.sv
// ---------------------------------------------------------------------------
// store_rmw
//
// Read-modify-write sequencer for store hits in the L1 data array. One 32-bit
// store (line index, word select, byte enables, data) is accepted at a time.
// The 256-bit line is read, handed to the external byte-merge stage together
// with the store fields, and the merged line is written back. A store to the
// same line accepted while the previous write is in progress skips the array
// read and merges into the line that is being written.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   st_valid/st_ready       store request handshake
//   st_idx/st_sel/st_wd/st_be  store line index, word select, data, byte enables
//   arr_rd_en/arr_rd_idx    data array read strobe and index
//   arr_rd_data             array read data, valid one cycle after arr_rd_en
//   mg_rd/mg_wd/mg_be/mg_sel   operands to the merge stage
//   mg_y                    merged line from the merge stage (combinational)
//   arr_wr_en/arr_wr_idx/arr_wr_data  data array write port
//   busy                    high in any state other than IDLE
//   fwd_cnt                 saturating count of read-skipped (forwarded) stores
// ---------------------------------------------------------------------------
module store_rmw #(
    parameter int IDX_W = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             st_valid,
    output logic             st_ready,
    input  logic [IDX_W-1:0] st_idx,
    input  logic [2:0]       st_sel,
    input  logic [31:0]      st_wd,
    input  logic [3:0]       st_be,

    output logic             arr_rd_en,
    output logic [IDX_W-1:0] arr_rd_idx,
    input  logic [255:0]     arr_rd_data,

    output logic [255:0]     mg_rd,
    output logic [31:0]      mg_wd,
    output logic [3:0]       mg_be,
    output logic [2:0]       mg_sel,
    input  logic [255:0]     mg_y,

    output logic             arr_wr_en,
    output logic [IDX_W-1:0] arr_wr_idx,
    output logic [255:0]     arr_wr_data,

    output logic             busy,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MG   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [2:0]         sel_q,   sel_d;
    logic [31:0]        wd_q,    wd_d;
    logic [3:0]         be_q,    be_d;
    logic [255:0]       line_q,  line_d;
    logic [CNT_W-1:0]   fwd_q,   fwd_d;

    logic               accept;

    // Strobes and ready are decoded from the state register; qualifying with
    // reset_n keeps them low for the whole time reset is held.
    assign st_ready  = reset_n & ((state_q == IDLE) | (state_q == WR));
    assign arr_rd_en = reset_n & (state_q == RD);
    assign arr_wr_en = reset_n & (state_q == WR);
    assign busy      = reset_n & (state_q != IDLE);

    assign accept    = st_valid & st_ready;

    assign arr_rd_idx  = idx_q;
    assign arr_wr_idx  = idx_q;
    // Write data is the merge result; it is held at zero outside WR so the
    // bus is quiet whenever no write is strobed.
    assign arr_wr_data = arr_wr_en ? mg_y : '0;

    assign mg_rd  = line_q;
    assign mg_wd  = wd_q;
    assign mg_be  = be_q;
    assign mg_sel = sel_q;

    assign fwd_cnt = fwd_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wd_d    = wd_q;
        be_d    = be_q;
        line_d  = line_q;
        fwd_d   = fwd_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = st_idx;
                    sel_d   = st_sel;
                    wd_d    = st_wd;
                    be_d    = st_be;
                    state_d = RD;
                end
            end

            RD: begin
                state_d = MG;
            end

            MG: begin
                line_d  = arr_rd_data;
                state_d = WR;
            end

            WR: begin
                // The merged line is kept so a same-line store accepted now
                // merges into it next cycle instead of re-reading the array.
                line_d = mg_y;
                if (accept) begin
                    idx_d = st_idx;
                    sel_d = st_sel;
                    wd_d  = st_wd;
                    be_d  = st_be;
                    if (st_idx == idx_q) begin
                        if (fwd_q != '1) begin
                            fwd_d = fwd_q + 1'b1;
                        end
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            line_q  <= '0;
            fwd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            line_q  <= line_d;
            fwd_q   <= fwd_d;
        end
    end

endmodule

// File: tb/tb_store_rmw.sv
// ---------------------------------------------------------------------------
// tb_store_rmw
//
// Directed bench for store_rmw. Provides a small data-array model (registered
// read, one-cycle latency) and a byte-merge model, then walks through single
// store, partial-byte, zero-byte-enable, same-line forwarding, line change,
// reset mid-operation and counter saturation cases with hand-computed values.
// ---------------------------------------------------------------------------
module tb_store_rmw;

    localparam int IDX_W = 15;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             st_valid;
    logic             st_ready;
    logic [IDX_W-1:0] st_idx;
    logic [2:0]       st_sel;
    logic [31:0]      st_wd;
    logic [3:0]       st_be;
    logic             arr_rd_en;
    logic [IDX_W-1:0] arr_rd_idx;
    logic [255:0]     arr_rd_data;
    logic [255:0]     mg_rd;
    logic [31:0]      mg_wd;
    logic [3:0]       mg_be;
    logic [2:0]       mg_sel;
    logic [255:0]     mg_y;
    logic             arr_wr_en;
    logic [IDX_W-1:0] arr_wr_idx;
    logic [255:0]     arr_wr_data;
    logic             busy;
    logic [CNT_W-1:0] fwd_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_rmw #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_idx     (st_idx),
        .st_sel     (st_sel),
        .st_wd      (st_wd),
        .st_be      (st_be),
        .arr_rd_en  (arr_rd_en),
        .arr_rd_idx (arr_rd_idx),
        .arr_rd_data(arr_rd_data),
        .mg_rd      (mg_rd),
        .mg_wd      (mg_wd),
        .mg_be      (mg_be),
        .mg_sel     (mg_sel),
        .mg_y       (mg_y),
        .arr_wr_en  (arr_wr_en),
        .arr_wr_idx (arr_wr_idx),
        .arr_wr_data(arr_wr_data),
        .busy       (busy),
        .fwd_cnt    (fwd_cnt)
    );

    // Byte-merge stage model.
    always_comb begin
        mg_y = mg_rd;
        for (int b = 0; b < 4; b++) begin
            if (mg_be[b]) begin
                mg_y[int'(mg_sel) * 32 + b * 8 +: 8] = mg_wd[b * 8 +: 8];
            end
        end
    end

    // Data array model plus strobe counters.
    logic [255:0] mem [0:31];
    logic         pl_en;
    logic [4:0]   pl_idx;
    logic [255:0] pl_val;
    logic         cnt_clr;
    int           rd_cnt;
    int           wr_cnt;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (arr_rd_en) arr_rd_data <= mem[arr_rd_idx[4:0]];
        if (arr_wr_en) mem[arr_wr_idx[4:0]] <= arr_wr_data;
        if (cnt_clr) begin
            rd_cnt <= 0;
            wr_cnt <= 0;
        end else begin
            if (arr_rd_en) rd_cnt <= rd_cnt + 1;
            if (arr_wr_en) wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [IDX_W-1:0] idx, input logic [2:0] sel,
                         input logic [31:0] wd, input logic [3:0] be);
        st_valid = 1'b1;
        st_idx   = idx;
        st_sel   = sel;
        st_wd    = wd;
        st_be    = be;
    endtask

    task automatic idle();
        st_valid = 1'b0;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [255:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_idx   = '0;
        st_sel   = '0;
        st_wd    = '0;
        st_be    = '0;
        pl_en    = 1'b0;
        pl_idx   = '0;
        pl_val   = '0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr = 1'b0;
        preload(5'd5,  '0);
        preload(5'd7,  '1);
        preload(5'd9,  '0);
        preload(5'd10, '0);
        preload(5'd3,  '0);

        // Reset state
        #1;
        chk("rst_st_ready",  256'(st_ready),    256'(1'b0));
        chk("rst_busy",      256'(busy),        256'(1'b0));
        chk("rst_rd_en",     256'(arr_rd_en),   256'(1'b0));
        chk("rst_wr_en",     256'(arr_wr_en),   256'(1'b0));
        chk("rst_fwd_cnt",   256'(fwd_cnt),     256'(0));
        chk("rst_mg_rd",     mg_rd,             256'(0));
        chk("rst_mg_wd",     256'(mg_wd),       256'(0));
        chk("rst_rd_idx",    256'(arr_rd_idx),  256'(0));
        chk("rst_wr_data",   arr_wr_data,       256'(0));
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_st_ready",  256'(st_ready),    256'(1'b1));

        // Single store: line 5 = 0, sel 3, full word
        store(15'd5, 3'd3, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t1_ready_idle", 256'(st_ready),    256'(1'b1));
        tick(); idle(); #1;
        chk("t1_rd_en",      256'(arr_rd_en),   256'(1'b1));
        chk("t1_rd_idx",     256'(arr_rd_idx),  256'(5));
        chk("t1_ready_rd",   256'(st_ready),    256'(1'b0));
        chk("t1_busy_rd",    256'(busy),        256'(1'b1));
        chk("t1_wr_en_rd",   256'(arr_wr_en),   256'(1'b0));
        tick(); #1;
        chk("t1_rd_en_mg",   256'(arr_rd_en),   256'(1'b0));
        chk("t1_wr_en_mg",   256'(arr_wr_en),   256'(1'b0));
        chk("t1_ready_mg",   256'(st_ready),    256'(1'b0));
        tick(); #1;
        chk("t1_wr_en",      256'(arr_wr_en),   256'(1'b1));
        chk("t1_rd_en_wr",   256'(arr_rd_en),   256'(1'b0));
        chk("t1_wr_idx",     256'(arr_wr_idx),  256'(5));
        chk("t1_wr_data",    arr_wr_data,       {128'h0, 32'hDEADBEEF, 96'h0});
        tick(); #1;
        chk("t1_busy_after", 256'(busy),        256'(1'b0));
        chk("t1_rd_cnt",     256'(rd_cnt),      256'(1));
        chk("t1_wr_cnt",     256'(wr_cnt),      256'(1));
        chk("t1_fwd_cnt",    256'(fwd_cnt),     256'(0));

        // Partial bytes: line 7 = all ones, sel 7, be 0101, data 0
        store(15'd7, 3'd7, 32'h0, 4'b0101);
        tick(); idle(); tick(); tick(); #1;
        chk("t2_wr_en",      256'(arr_wr_en),   256'(1'b1));
        chk("t2_wr_data",    arr_wr_data,       {32'hFF00FF00, {224{1'b1}}});
        tick();

        // Zero byte enables: line written back unchanged
        store(15'd7, 3'd0, 32'h12345678, 4'b0000);
        tick(); idle(); tick(); tick(); #1;
        chk("t2b_wr_en",     256'(arr_wr_en),   256'(1'b1));
        chk("t2b_wr_data",   arr_wr_data,       {32'hFF00FF00, {224{1'b1}}});
        tick();

        // Forwarding: idx 9, sel 0, 1, 2
        clr();
        store(15'd9, 3'd0, 32'h11111111, 4'hF);
        tick();
        store(15'd9, 3'd1, 32'h22222222, 4'hF);
        #1;
        chk("t3_ready_rd",   256'(st_ready),    256'(1'b0));
        tick(); tick(); #1;
        chk("t3_wr0_en",     256'(arr_wr_en),   256'(1'b1));
        chk("t3_wr0_ready",  256'(st_ready),    256'(1'b1));
        chk("t3_wr0_data",   arr_wr_data,       {224'h0, 32'h11111111});
        tick();
        store(15'd9, 3'd2, 32'h33333333, 4'hF);
        #1;
        chk("t3_wr1_en",     256'(arr_wr_en),   256'(1'b1));
        chk("t3_wr1_no_rd",  256'(arr_rd_en),   256'(1'b0));
        chk("t3_wr1_data",   arr_wr_data,       {192'h0, 32'h22222222, 32'h11111111});
        tick(); idle(); #1;
        chk("t3_wr2_en",     256'(arr_wr_en),   256'(1'b1));
        chk("t3_wr2_data",   arr_wr_data,       {160'h0, 32'h33333333, 32'h22222222, 32'h11111111});
        chk("t3_fwd_cnt",    256'(fwd_cnt),     256'(2));
        tick(); #1;
        chk("t3_busy_after", 256'(busy),        256'(1'b0));
        chk("t3_rd_cnt",     256'(rd_cnt),      256'(1));
        chk("t3_wr_cnt",     256'(wr_cnt),      256'(3));

        // Line change from WR: idx 9 then idx 10
        clr();
        store(15'd9, 3'd4, 32'hAAAAAAAA, 4'hF);
        tick(); idle(); tick(); tick();
        store(15'd10, 3'd5, 32'h55555555, 4'hF);
        #1;
        chk("t4_wr9_en",     256'(arr_wr_en),   256'(1'b1));
        chk("t4_wr9_idx",    256'(arr_wr_idx),  256'(9));
        chk("t4_wr9_data",   arr_wr_data,
            {96'h0, 32'hAAAAAAAA, 32'h0, 32'h33333333, 32'h22222222, 32'h11111111});
        chk("t4_wr9_ready",  256'(st_ready),    256'(1'b1));
        tick(); idle(); #1;
        chk("t4_rd10_en",    256'(arr_rd_en),   256'(1'b1));
        chk("t4_rd10_idx",   256'(arr_rd_idx),  256'(10));
        chk("t4_rd10_no_wr", 256'(arr_wr_en),   256'(1'b0));
        tick(); tick(); #1;
        chk("t4_wr10_en",    256'(arr_wr_en),   256'(1'b1));
        chk("t4_wr10_idx",   256'(arr_wr_idx),  256'(10));
        chk("t4_wr10_data",  arr_wr_data,       {64'h0, 32'h55555555, 160'h0});
        chk("t4_fwd_cnt",    256'(fwd_cnt),     256'(2));
        tick();

        // Reset asserted during MG
        clr();
        store(15'd5, 3'd0, 32'hCAFEF00D, 4'hF);
        tick(); idle(); tick();
        reset_n = 1'b0;
        #1;
        chk("t5_busy",       256'(busy),        256'(1'b0));
        chk("t5_ready",      256'(st_ready),    256'(1'b0));
        chk("t5_wr_en",      256'(arr_wr_en),   256'(1'b0));
        chk("t5_fwd_cnt",    256'(fwd_cnt),     256'(0));
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("t5_rel_ready",  256'(st_ready),    256'(1'b1));
        chk("t5_rel_busy",   256'(busy),        256'(1'b0));
        tick(); tick(); tick(); tick(); #1;
        chk("t5_wr_cnt",     256'(wr_cnt),      256'(0));
        chk("t5_rd_cnt",     256'(rd_cnt),      256'(1));

        // Saturation: 20 same-line stores, 19 of them forwarded
        clr();
        for (int i = 0; i < 20; i++) begin
            int waited;
            store(15'd3, 3'(i % 8), 32'(i), 4'b0001);
            #1;
            waited = 0;
            while (!st_ready && waited < 10) begin
                tick(); #1;
                waited++;
            end
            chk("t6_accept_ready", 256'(st_ready), 256'(1'b1));
            tick();
        end
        idle();
        tick(); tick(); #1;
        chk("t6_fwd_sat",    256'(fwd_cnt),     256'(4'hF));
        chk("t6_rd_cnt",     256'(rd_cnt),      256'(1));
        chk("t6_wr_cnt",     256'(wr_cnt),      256'(20));
        chk("t6_busy",       256'(busy),        256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw.md
# store_rmw

Read-modify-write sequencer for store hits in the 1 MB L1 data array. Accepts one 32-bit store (line index, word select, byte enables, data), reads the 256-bit line, drives the byte-merge stage, and writes the merged line back. It sits directly upstream of the merge stage, supplying its `rd`/`wd`/`be`/`sel` inputs and consuming its `y` output, between the store-hit path and the data array write port. Back-to-back stores to the same line bypass the array read: the previously merged line is forwarded.

## Interface
- `IDX_W`, 15: line index width (32768 lines × 32 B).
- `CNT_W`, 16: width of the forwarding statistics counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: store request accepted when `st_valid & st_ready`.
- `st_idx` in IDX_W: line index.
- `st_sel` in 3: word within line (0 = bits 31:0, 7 = bits 255:224).
- `st_wd` in 32: store data.
- `st_be` in 4: byte enables; bit n selects byte n of the word.
- `arr_rd_en` out 1: data array read strobe.
- `arr_rd_idx` out IDX_W: read index.
- `arr_rd_data` in 256: array read data, valid exactly 1 cycle after `arr_rd_en`.
- `mg_rd` out 256: line to merge stage.
- `mg_wd` out 32, `mg_be` out 4, `mg_sel` out 3: to merge stage.
- `mg_y` in 256: merged line from merge stage (combinational).
- `arr_wr_en` out 1: data array write strobe.
- `arr_wr_idx` out IDX_W, `arr_wr_data` out 256: write index and data.
- `busy` out 1: high in any state other than IDLE.
- `fwd_cnt` out CNT_W: saturating count of forwarded (read-skipped) stores.

## Operation
- Request registers `idx_q`, `sel_q`, `wd_q`, `be_q` are loaded on every accept. `mg_wd`, `mg_be`, and `mg_sel` are driven from these registers. The line register `line_q` (256 bits) drives `mg_rd`.
- States: IDLE, RD, MG, WR.
- IDLE:
  - `st_ready` = 1.
  - On accept: load the request registers and go to RD.
- RD:
  - `arr_rd_en` = 1, `arr_rd_idx` = `idx_q`, `st_ready` = 0.
  - Go to MG.
- MG:
  - `line_q` <= `arr_rd_data`, `st_ready` = 0.
  - Go to WR.
- WR:
  - `arr_wr_en` = 1, `arr_wr_idx` = `idx_q`, `arr_wr_data` = `mg_y`; `line_q` <= `mg_y`.
  - `st_ready` = 1.
  - On accept with `st_idx == idx_q`: load the request registers, increment `fwd_cnt` (saturating at all-ones), and stay in WR. The next cycle merges into the forwarded `line_q`.
  - On accept with a different index: load the request registers and go to RD.
  - With no accept: go to IDLE.
- `st_ready` = `reset_n` & (state == IDLE | state == WR). `st_ready` is never high in RD or MG.
- `be = 0` is legal: the full RMW still occurs and the line is written back unchanged.
- `arr_rd_en` and `arr_wr_en` are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - `idx_q`, `sel_q`, `wd_q`, `be_q`, `line_q`, and `fwd_cnt` are 0.
  - `arr_rd_en`, `arr_wr_en`, `busy`, and `st_ready` are 0 while `reset_n` is low.
  - `arr_*_idx`, `arr_wr_data`, and `mg_*` are 0.
- Accept at cycle T (from IDLE) gives: `arr_rd_en` at T+1, `line_q` capture at T+2, `arr_wr_en` at T+3.
- Same-line accept in WR at cycle T: the next `arr_wr_en` is at T+1, with no read.
- Different-line accept in WR at cycle T: `arr_rd_en` at T+1, write at T+3.
- Throughput is 1 store every 3 cycles for distinct lines, and 1 per cycle for a same-line stream.
- The `arr_*` strobes and `st_ready` are decoded combinationally from the state register. Data outputs come from registers, except `arr_wr_data`, which is `mg_y`.
- Reset asserted mid-operation: immediately return to IDLE, drop all strobes, and abandon the in-flight store with no array write.

## Test plan
- Single store:
  - Stimulus: array line 5 = 256'h0; store idx=5, sel=3, be=4'b1111, wd=32'hDEADBEEF.
  - Required: `arr_rd_en` at T+1; `arr_wr_en` at T+3 with bits 127:96 = DEADBEEF and all other bits 0.
- Partial bytes:
  - Stimulus: line = all 1s; store sel=7, be=4'b0101, wd=0.
  - Required: written bits 255:224 = 32'hFF00FF00; bits 223:0 unchanged.
- Forwarding:
  - Stimulus: stores to idx 9 with sel 0, 1, 2 on consecutive cycles, starting with the sel=0 store when in IDLE.
  - Required: exactly one array read; writes on 3 consecutive cycles; the final line holds all three words; `fwd_cnt` = 2.
- Line change from WR:
  - Stimulus: store idx 9 followed, while in WR, by a store to idx 10.
  - Required: a second `arr_rd_en` with idx 10 in the cycle after the first write; the idx 10 write lands 3 cycles after its accept.
- Reset mid-op:
  - Stimulus: deassert `reset_n` during MG.
  - Required: no `arr_wr_en` ever; `busy` = 0, `fwd_cnt` = 0; `st_ready` = 1 on the first cycle after release.
- Saturation:
  - Stimulus: force `fwd_cnt` near all-ones with CNT_W=4; issue 20 same-line stores.
  - Required: `fwd_cnt` holds at 4'hF.
